// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-wait freeze, branch redirect with deferred
// replay across waits, load-use bubble insertion and saturating event counters.
module hazard_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_rm_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_branch,
    input  logic        mem_uncond_branch,
    input  logic        mem_zero,
    input  logic        mem_wait,
    input  logic        cnt_clear,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        mem_wb_write,
    output logic        id_ex_bubble,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        pc_src,
    output logic        waiting,
    output logic        redirect_pending,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] wait_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic   pending_reg, pending_next;

    logic taken;
    logic load_use;
    logic redirect;
    logic stall;
    logic [2:0]       cnt_inc;
    logic [2:0][15:0] cnt_val;

    assign taken    = mem_uncond_branch | (mem_branch & mem_zero);
    assign load_use = ex_mem_read & (ex_rd != 5'd31) &
                      ((ex_rd == id_rn) | (id_rm_valid & (ex_rd == id_rm)));
    assign redirect = !mem_wait && (taken || pending_reg);
    assign stall    = !mem_wait && !redirect && load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

    // A branch resolving while memory stalls is remembered and replayed on release.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        pc_src       = 1'b0;
        state_next   = ST_RUN;
        pending_next = pending_reg;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (mem_wait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            state_next   = ST_WAIT;
            pending_next = pending_reg | taken;
        end else if (redirect) begin
            pc_src       = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            pending_next = 1'b0;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign waiting          = (state_reg == ST_WAIT);
    assign redirect_pending = pending_reg;

    // Counter order: 0 = stall, 1 = flush, 2 = wait.
    assign cnt_inc = {mem_wait, redirect, stall};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clear) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];
    assign wait_cnt  = cnt_val[2];

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a cycle model pushes expected control
// vectors to a queue when stimulus is applied; they are popped at the falling edge.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rn = '0, id_rm = '0, ex_rd = '0;
    logic        id_rm_valid = 1'b0, ex_mem_read = 1'b0;
    logic        mem_branch = 1'b0, mem_uncond_branch = 1'b0, mem_zero = 1'b0;
    logic        mem_wait = 1'b0, cnt_clear = 1'b0;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic        id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, pc_src;
    logic        waiting, redirect_pending;
    logic [15:0] stall_cnt, flush_cnt, wait_cnt;

    hazard_controller dut (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_rm_valid(id_rm_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_uncond_branch(mem_uncond_branch), .mem_zero(mem_zero),
        .mem_wait(mem_wait), .cnt_clear(cnt_clear),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .id_ex_bubble(id_ex_bubble), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .pc_src(pc_src),
        .waiting(waiting), .redirect_pending(redirect_pending),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mw, u, b, z, mr;
        logic [4:0] rd, rn, rm;
        logic       rmv, clr;
    } stim_t;

    int checks = 0;
    int errors = 0;

    // Control vector: {pc_w, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, bubble, f_if_id, f_id_ex, f_ex_mem, pc_src, waiting, pending}
    logic [11:0] ctl;
    assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                  id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, pc_src,
                  waiting, redirect_pending};

    logic [11:0] exp_q[$];
    logic        m_wait = 1'b0, m_pend = 1'b0, n_wait = 1'b0, n_pend = 1'b0;
    logic [15:0] m_sc = '0, m_fc = '0, m_wc = '0, n_sc = '0, n_fc = '0, n_wc = '0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Apply one cycle of stimulus and push the expected control vector.
    task automatic drive(input stim_t s);
        logic       tk, lu, bub, fl, ps;
        logic [4:0] en;
        mem_wait = s.mw; mem_uncond_branch = s.u; mem_branch = s.b; mem_zero = s.z;
        ex_mem_read = s.mr; ex_rd = s.rd; id_rn = s.rn; id_rm = s.rm;
        id_rm_valid = s.rmv; cnt_clear = s.clr;
        tk = s.u | (s.b & s.z);
        lu = s.mr && (s.rd != 5'd31) && ((s.rd == s.rn) || (s.rmv && (s.rd == s.rm)));
        en = 5'b11111; bub = 1'b0; fl = 1'b0; ps = 1'b0;
        n_wait = 1'b0; n_pend = m_pend; n_sc = m_sc; n_fc = m_fc; n_wc = m_wc;
        if (s.mw) begin
            en = 5'b00000; n_wait = 1'b1; n_pend = m_pend | tk; n_wc = sat_inc(m_wc);
        end else if (tk || m_pend) begin
            fl = 1'b1; ps = 1'b1; n_pend = 1'b0; n_fc = sat_inc(m_fc);
        end else if (lu) begin
            en = 5'b00111; bub = 1'b1; n_sc = sat_inc(m_sc);
        end
        if (s.clr) begin
            n_sc = '0; n_fc = '0; n_wc = '0;
        end
        exp_q.push_back({en, bub, fl, fl, fl, ps, m_wait, m_pend});
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_wait = n_wait; m_pend = n_pend; m_sc = n_sc; m_fc = n_fc; m_wc = n_wc;
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_pend = 1'b0; m_sc = '0; m_fc = '0; m_wc = '0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        mem_wait = 1'b1; mem_uncond_branch = 1'b1; ex_mem_read = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(12'h000);
        e = exp_q.pop_front();
        checks++;
        if (ctl !== e || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || wait_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold ctl=%b cnt=%h/%h/%h expected ctl=%b cnt=0", ctl, stall_cnt, flush_cnt, wait_cnt, e);
        end else $display("reset_hold ctl=%b", ctl);
        drive('0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        drive('0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (ctl !== e) begin
            errors++;
            $display("FAIL reset_first_run ctl=%b expected=%b", ctl, e);
        end else $display("reset_first_run ctl=%b", ctl);
        advance();
    endtask

    task automatic test_load_use();
        stim_t tbl [4];
        logic [11:0] e;
        tbl = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd4, 1'b1, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL load_use[%0d] ctl=%b expected=%b", i, ctl, e);
            end else $display("load_use[%0d] ctl=%b", i, ctl);
            advance();
            if (i == 0) begin
                checks++;
                if (stall_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL load_use_cnt stall_cnt=%0d expected=1", stall_cnt);
                end
            end
        end
        checks++;
        if (stall_cnt !== m_sc) begin
            errors++;
            $display("FAIL load_use_total stall_cnt=%0d expected=%0d", stall_cnt, m_sc);
        end
    endtask

    task automatic test_xzr();
        stim_t tbl [3];
        logic [11:0] e;
        tbl = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL xzr[%0d] ctl=%b expected=%b", i, ctl, e);
            end else $display("xzr[%0d] ctl=%b", i, ctl);
            advance();
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL xzr_cnt stall_cnt=%0d expected=0", stall_cnt);
        end
    endtask

    task automatic test_branch_wait();
        stim_t tbl [6];
        logic [11:0] e;
        tbl = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1},
                '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0},
                '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0},
                '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL branch_wait[%0d] ctl=%b expected=%b", i, ctl, e);
            end else $display("branch_wait[%0d] ctl=%b", i, ctl);
            advance();
            if (i == 4) begin
                checks++;
                if (wait_cnt !== 16'd3 || flush_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL branch_wait_cnt wait_cnt=%0d flush_cnt=%0d expected 3 and 1", wait_cnt, flush_cnt);
                end
            end
        end
    endtask

    task automatic test_priority();
        stim_t tbl [3];
        logic [11:0] e;
        logic [15:0] sc0;
        sc0 = m_sc;
        tbl = '{'{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0},
                '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL priority[%0d] ctl=%b expected=%b", i, ctl, e);
            end else $display("priority[%0d] ctl=%b", i, ctl);
            advance();
            if (i == 1) begin
                checks++;
                if (stall_cnt !== sc0) begin
                    errors++;
                    $display("FAIL priority_cnt stall_cnt=%0d expected=%0d", stall_cnt, sc0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl [4];
        logic [11:0] e;
        tbl = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd1, 5'd6, 1'b1, 1'b0},
                '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0},
                '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] ctl=%b expected=%b", i, ctl, e);
            end else $display("back_to_back[%0d] ctl=%b", i, ctl);
            advance();
        end
        checks++;
        if (stall_cnt !== m_sc || flush_cnt !== m_fc || wait_cnt !== m_wc) begin
            errors++;
            $display("FAIL back_to_back_cnt cnt=%0d/%0d/%0d expected=%0d/%0d/%0d",
                     stall_cnt, flush_cnt, wait_cnt, m_sc, m_fc, m_wc);
        end
    endtask

    task automatic test_saturation();
        stim_t lu_s, clr_s;
        logic [11:0] e;
        lu_s  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0};
        clr_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1};
        for (int i = 0; i < 70000; i++) begin
            drive(lu_s);
            void'(exp_q.pop_front());
            advance();
        end
        checks++;
        if (stall_cnt !== 16'hFFFF || stall_cnt !== m_sc) begin
            errors++;
            $display("FAIL saturate stall_cnt=%h expected=ffff", stall_cnt);
        end else $display("saturate stall_cnt=%h after 70000 load-use cycles", stall_cnt);
        drive(clr_s);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (ctl !== e) begin
            errors++;
            $display("FAIL clear_cycle ctl=%b expected=%b", ctl, e);
        end else $display("clear_cycle ctl=%b", ctl);
        advance();
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clear_priority stall_cnt=%0d expected=0", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t w_tk, w_nt, lu_s;
        logic [11:0] e;
        w_tk = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        w_nt = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        lu_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            drive((i == 0) ? w_tk : w_nt);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL mid_wait[%0d] ctl=%b expected=%b", i, ctl, e);
            end else $display("mid_wait[%0d] ctl=%b", i, ctl);
            if (i == 0) advance();
        end
        mem_uncond_branch = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        exp_q.push_back(12'h000);
        e = exp_q.pop_front();
        checks++;
        if (ctl !== e || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || wait_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_wait ctl=%b cnt=%h/%h/%h expected ctl=%b cnt=0", ctl, stall_cnt, flush_cnt, wait_cnt, e);
        end else $display("reset_mid_wait ctl=%b", ctl);
        @(posedge clk);
        #1;
        exp_q.push_back(12'h000);
        e = exp_q.pop_front();
        checks++;
        if (ctl !== e) begin
            errors++;
            $display("FAIL reset_held_edge ctl=%b expected=%b", ctl, e);
        end else $display("reset_held_edge ctl=%b", ctl);
        drive('0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(lu_s);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (ctl !== e) begin
            errors++;
            $display("FAIL after_reset ctl=%b expected=%b", ctl, e);
        end else $display("after_reset ctl=%b", ctl);
        advance();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_xzr();
        test_branch_wait();
        test_priority();
        test_back_to_back();
        test_saturation();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have ports id_rn, id_rm, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have port id_rm_valid, input, 1 bit: id_rm is actually read.
REQ-005 SHALL have ports ex_mem_read, input, 1 bit, and ex_rd, input, 5 bits: load flag and destination of the instruction in EX.
REQ-006 SHALL have ports mem_branch, mem_uncond_branch, mem_zero, input, 1 bit each: branch controls and ALU zero flag of the instruction in MEM.
REQ-007 SHALL have port mem_wait, input, 1 bit: data memory not ready.
REQ-008 SHALL have port cnt_clear, input, 1 bit: synchronous clear of all counters.
REQ-009 SHALL have ports pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write, output, 1 bit each: per-register update enables.
REQ-010 SHALL have ports id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, pc_src, output, 1 bit each.
REQ-011 SHALL have ports waiting and redirect_pending, output, 1 bit each: state visibility.
REQ-012 SHALL have ports stall_cnt, flush_cnt, wait_cnt, output, 16 bits each.

Function
REQ-013 SHALL define taken = mem_uncond_branch | (mem_branch & mem_zero).
REQ-014 SHALL define load_use = ex_mem_read & (ex_rd != 31) & ((ex_rd == id_rn) | (id_rm_valid & ex_rd == id_rm)).
REQ-015 SHALL hold state RUN or WAIT, plus a redirect_pending flag; waiting = 1 in WAIT.
REQ-016 SHALL derive all control outputs combinationally from state, pending and inputs in the same cycle, with priority mem_wait > redirect > load_use > normal.
REQ-017 Normal: all five write enables 1; flushes, bubble and pc_src 0.
REQ-018 mem_wait = 1: all five write enables 0; flushes, bubble and pc_src 0; next state WAIT.
REQ-019 In WAIT with mem_wait = 1 and taken = 1: SHALL set redirect_pending at the clock edge.
REQ-020 Redirect applies when mem_wait = 0 and (taken or redirect_pending): pc_src, flush_if_id, flush_id_ex and flush_ex_mem = 1; all write enables 1; id_ex_bubble 0; pending cleared; next state RUN.
REQ-021 Load-use, only when no wait and no redirect: pc_write = 0, if_id_write = 0, id_ex_bubble = 1; other enables 1; exactly one bubble per hazard cycle.
REQ-022 WAIT -> RUN on the first cycle with mem_wait = 0; that cycle SHALL be evaluated with full RUN priority.
REQ-023 stall_cnt SHALL increment on each load-use cycle; flush_cnt on each redirect cycle; wait_cnt on each mem_wait cycle.
REQ-024 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-025 cnt_clear SHALL zero all counters at the edge and take priority over any increment in the same cycle.
REQ-026 ex_rd = 31 (XZR) SHALL never cause a stall.

Reset
REQ-027 rst_n low SHALL immediately force state RUN, redirect_pending 0 and all counters 0.
REQ-028 While rst_n is low, all write enables, flushes, id_ex_bubble and pc_src SHALL be 0.
REQ-029 Reset asserted mid-WAIT or with a pending redirect SHALL discard the wait and the redirect.
REQ-030 The first edge after rst_n rises SHALL operate in RUN.

Verification
REQ-031 Load-use: ex_mem_read = 1, ex_rd = 5, id_rn = 5 for one cycle -> pc_write = 0, if_id_write = 0, id_ex_bubble = 1 that cycle; stall_cnt = 1.
REQ-032 XZR / unused rm: ex_rd = 31 = id_rn, then ex_rd = 7 = id_rm with id_rm_valid = 0 -> no stall; stall_cnt = 0.
REQ-033 Branch under wait: mem_wait = 1 for 3 cycles with taken pulsed in cycle 1, then mem_wait = 0 -> enables 0 for 3 cycles, redirect_pending = 1, and in cycle 4 pc_src = 1 with all three flushes; wait_cnt = 3, flush_cnt = 1.
REQ-034 Priority: taken and load_use in the same cycle -> redirect only (pc_src = 1, id_ex_bubble = 0); stall_cnt unchanged.
REQ-035 Saturation/clear: force 70000 load-use cycles -> stall_cnt = 16'hFFFF; cnt_clear together with load_use -> stall_cnt = 0.
REQ-036 Reset: assert rst_n low during WAIT with pending set -> waiting = 0, redirect_pending = 0, counters 0, all outputs 0 while low.
